// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared state and error-cause encodings for count_monitor
package count_mon_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_INIT  = 2'd0;
  localparam state_t S_TRACK = 2'd1;
  localparam state_t S_SAT   = 2'd2;
  localparam state_t S_FAULT = 2'd3;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVER = 2'd1,
    ERR_JUMP = 2'd2,
    ERR_INIT = 2'd3
  } err_code_e;

endpackage

// File: rtl/count_monitor_if.sv
// rtl/count_monitor_if.sv - observed count, clear request and monitor status bundle
interface count_monitor_if #(
  parameter int WIDTH = 3
);

  logic [WIDTH-1:0] cnt_in;
  logic             clr_err;
  logic             sat_pulse;
  logic             err;
  logic [1:0]       err_code;
  logic [7:0]       err_count;

  modport master (
    output cnt_in, clr_err,
    input  sat_pulse, err, err_code, err_count
  );

  modport slave (
    input  cnt_in, clr_err,
    output sat_pulse, err, err_code, err_count
  );

endinterface

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - checks a bounded up-counter for illegal steps and reports faults
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             resetn,
  count_monitor_if.slave   bus
);

  // One extra bit so MAX-1, prev+1 and the over-range compare cannot wrap.
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] PRE_X = (WIDTH+1)'(MAX - 1);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  state_t           state, state_d;
  logic [WIDTH-1:0] prev;
  logic             sat_q, sat_d;
  logic             err_q;
  err_code_e        code_q;
  logic [7:0]       count_q;

  logic [WIDTH:0]   cur_x, prev_x;
  logic             over, legal, viol;
  err_code_e        cause, step_cause;

  assign cur_x      = {1'b0, bus.cnt_in};
  assign prev_x     = {1'b0, prev};
  assign over       = cur_x > MAX_X;
  assign legal      = !over && ((cur_x == prev_x) || (cur_x == prev_x + ONE_X));
  assign step_cause = over ? ERR_OVER : ERR_JUMP;

  always_comb begin
    state_d = state;
    sat_d   = 1'b0;
    viol    = 1'b0;
    cause   = ERR_NONE;
    case (state)
      S_INIT: begin
        if (cur_x == '0) begin
          state_d = S_TRACK;
        end else begin
          viol    = 1'b1;
          cause   = ERR_INIT;
          state_d = S_FAULT;
        end
      end
      S_TRACK: begin
        if (!legal) begin
          viol    = 1'b1;
          cause   = step_cause;
          state_d = S_FAULT;
        end else if (prev_x == PRE_X && cur_x == MAX_X) begin
          state_d = S_SAT;
          sat_d   = 1'b1;
        end
      end
      S_SAT: begin
        if (cur_x != MAX_X) begin
          viol    = 1'b1;
          cause   = step_cause;
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        // A return to zero is the recovery path and is never itself a violation.
        if (cur_x == '0) begin
          state_d = S_TRACK;
        end else if (!legal) begin
          viol  = 1'b1;
          cause = step_cause;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_INIT;
      prev    <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      count_q <= 8'd0;
    end else begin
      state <= state_d;
      prev  <= bus.cnt_in;
      sat_q <= sat_d;
      if (viol) begin
        // A clear coinciding with a violation restarts the record from this cause.
        err_q <= 1'b1;
        if (!err_q || bus.clr_err) begin
          code_q <= cause;
        end
        if (bus.clr_err) begin
          count_q <= 8'd1;
        end else if (count_q != 8'hFF) begin
          count_q <= count_q + 8'd1;
        end
      end else if (bus.clr_err) begin
        err_q   <= 1'b0;
        code_q  <= ERR_NONE;
        count_q <= 8'd0;
      end
    end
  end

  assign bus.sat_pulse = sat_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.err_count = count_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - scoreboard bench for count_monitor with directed vectors
module tb_count_monitor;

  typedef struct {
    logic       sat;
    logic       err;
    logic [1:0] code;
    logic [7:0] count;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  count_monitor_if #(.WIDTH(3)) bus ();

  count_monitor #(.WIDTH(3), .MAX(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are valid every cycle, so compare one entry per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.sat_pulse !== e.sat || bus.err !== e.err ||
            bus.err_code !== e.code || bus.err_count !== e.count) begin
          errors++;
          $display("FAIL %s: got sat=%0d err=%0d code=%0d count=%0d, want sat=%0d err=%0d code=%0d count=%0d",
                   e.name, bus.sat_pulse, bus.err, bus.err_code, bus.err_count,
                   e.sat, e.err, e.code, e.count);
        end
      end
    end
  end

  task automatic step(input logic [2:0] c, input logic clr, input logic es, input logic ee,
                      input logic [1:0] ec, input logic [7:0] en, input string nm);
    exp_t e;
    @(negedge clk);
    bus.cnt_in  = c;
    bus.clr_err = clr;
    resetn      = 1'b1;
    e.sat = es; e.err = ee; e.code = ec; e.count = en; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Asserts reset between clock edges and checks that outputs clear without a clock.
  task automatic async_reset(input string nm);
    drain();
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.sat_pulse !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 2'd0 ||
        bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL %s: got sat=%0d err=%0d code=%0d count=%0d, want all 0",
               nm, bus.sat_pulse, bus.err, bus.err_code, bus.err_count);
    end
  endtask

  initial begin
    bus.cnt_in  = 3'd0;
    bus.clr_err = 1'b0;
    #12;
    checks++;
    if (bus.sat_pulse !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 2'd0 ||
        bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL por: got sat=%0d err=%0d code=%0d count=%0d, want all 0",
               bus.sat_pulse, bus.err, bus.err_code, bus.err_count);
    end

    // Clean count up to saturation and hold.
    step(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "up0");
    step(3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "up1");
    step(3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "up2");
    step(3'd3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, "up3_pulse");
    step(3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "hold3");

    // Nonzero first sample after reset.
    async_reset("rst_a");
    step(3'd2, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1, "init_viol");
    step(3'd2, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1, "fault_hold");
    step(3'd0, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1, "fault_ret0");
    step(3'd1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1, "track1");
    step(3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, "clear");

    // Jump, then further over-range violations keep the first cause.
    async_reset("rst_b");
    step(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "j0");
    step(3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "j1");
    step(3'd3, 1'b0, 1'b0, 1'b1, 2'd2, 8'd1, "jump");
    step(3'd5, 1'b0, 1'b0, 1'b1, 2'd2, 8'd2, "first_kept");
    step(3'd5, 1'b0, 1'b0, 1'b1, 2'd2, 8'd3, "over_hold");

    // Over-range from saturation, recovery, and a second pulse while err is set.
    async_reset("rst_c");
    step(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "o0");
    step(3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "o1");
    step(3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "o2");
    step(3'd3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, "o3_pulse");
    step(3'd4, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, "over");
    step(3'd0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, "recover");
    step(3'd1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, "r1");
    step(3'd2, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, "r2");
    step(3'd3, 1'b0, 1'b1, 1'b1, 2'd1, 8'd1, "r3_pulse");

    // Clear coinciding with a violation: new cause replaces the old one.
    async_reset("rst_d");
    step(3'd5, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1, "init5");
    step(3'd0, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1, "ret0");
    step(3'd2, 1'b1, 1'b0, 1'b1, 2'd2, 8'd1, "clr_with_jump");
    step(3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, "clr_clean");
    step(3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "fault_step_ok");

    // Sustained over-range value saturates the violation counter.
    async_reset("rst_e");
    step(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, "s0");
    for (int i = 0; i < 300; i++) begin
      step(3'd7, 1'b0, 1'b0, 1'b1, 2'd1, (i < 255) ? 8'(i + 1) : 8'd255, "sat_count");
    end
    async_reset("rst_mid_fault");
    step(3'd2, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1, "post_rst_init");

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WIDTH, default 3, width of the observed count bus.
REQ-002 Parameter MAX, default 3, highest legal count value; SHALL satisfy MAX < 2**WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 cnt_in  input  WIDTH  count value from the bounded up-counter under observation, sampled every cycle.
REQ-006 clr_err  input  1  synchronous request to clear err, err_code and err_count.
REQ-007 sat_pulse  output  1  one-cycle pulse when the observed count reaches MAX from MAX-1.
REQ-008 err  output  1  sticky violation flag.
REQ-009 err_code  output  2  cause of the first violation since the last clear: 0 NONE, 1 OVER, 2 JUMP, 3 INIT.
REQ-010 err_count  output  8  number of violating cycles, saturating at 255.

Function
REQ-011 The block SHALL register cnt_in into prev each cycle; every check SHALL compare the current cnt_in against prev.
REQ-012 FSM states SHALL be S_INIT, S_TRACK, S_SAT and S_FAULT.
REQ-013 S_INIT covers the first sample after reset: cnt_in == 0 -> S_TRACK; cnt_in != 0 -> INIT violation, then S_FAULT.
REQ-014 In S_TRACK the legal events are cnt_in == prev and cnt_in == prev+1 (<= MAX); prev == MAX-1 with cnt_in == MAX SHALL go to S_SAT.
REQ-015 In S_SAT the only legal value SHALL be cnt_in == MAX; any other value is a violation, then S_FAULT.
REQ-016 Classification, by priority: cnt_in > MAX -> OVER; otherwise any change that is not hold or +1 -> JUMP.
REQ-017 In S_FAULT checks SHALL continue against prev. Every violating cycle SHALL increment err_count. cnt_in == 0 SHALL return to S_TRACK, with no violation recorded for that return.
REQ-018 sat_pulse SHALL be registered, high for exactly one cycle, in the cycle after the MAX-1 -> MAX sample; it SHALL NOT be asserted in S_INIT or S_FAULT.
REQ-019 err SHALL set on the cycle after a violation sample and hold until clr_err. err_code SHALL latch only when err is 0 (first cause).
REQ-020 clr_err without a violation in the same cycle SHALL clear err to 0, err_code to NONE and err_count to 0 in the next cycle.
REQ-021 clr_err with a violation in the same cycle: the violation wins; err = 1, err_code = the new cause, err_count = 1.
REQ-022 err_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-023 All outputs SHALL be registered; latency from cnt_in sample to output SHALL be 1 cycle.

Reset
REQ-024 resetn low SHALL asynchronously force state to S_INIT, prev to 0, sat_pulse to 0, err to 0, err_code to NONE and err_count to 0.
REQ-025 A reset during any state, including S_FAULT or mid-pulse, SHALL abort immediately; the first sample after release SHALL follow REQ-013.
REQ-026 Reset release SHALL be clean for synchronous logic (deassertion synchronized upstream).

Structure
REQ-027 The state enum and the err_code encodings (NONE, OVER, JUMP, INIT) SHALL live in a shared package, count_mon_pkg.
REQ-028 The block SHALL be a single module with no sub-modules; the err_count saturating counter is inline logic.

Verification
REQ-029 Reset, then cnt_in 0,1,2,3,3 -> sat_pulse high only in the cycle after the 2->3 sample; err stays 0.
REQ-030 Reset release with cnt_in = 2 -> next cycle err = 1, err_code = 3 (INIT), err_count = 1.
REQ-031 Sequence 0,1,3 -> err_code = 2 (JUMP); then 5 -> err_code stays 2, err_count = 2.
REQ-032 Sequence 0,1,2,3 then cnt_in = 4 -> err_code = 1 (OVER); then cnt_in = 0 -> state S_TRACK, err stays 1.
REQ-033 clr_err asserted together with a jump 0 -> 2 -> err = 1, err_code = 2, err_count = 1.
REQ-034 Hold an illegal value (e.g. 7) for 300 cycles -> err_count = 255; resetn pulsed low mid-run -> all outputs 0 asynchronously.
